sram_like_axi_bridge: RTL and testbench



---
 rtl/sram_like_axi_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_sram_like_axi_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_axi_bridge.sv
// sram_like_axi_bridge: turns one sram-like request into one single-beat
// AXI4 read or write, and reports completion to the core with data_ok.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req/wr/size/addr/wdata : sram-like request from the core
//   addr_ok/data_ok/rdata  : sram-like accept, completion and read data
//   ar*/r*          : AXI read address and read data channels
//   aw*/w*/b*       : AXI write address, write data and write response

module sram_like_axi_bridge #(
    parameter int                     ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0]    AXI_ID   = ID_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    // sram-like side
    input  logic                req,
    input  logic                wr,
    input  logic [1:0]          size,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [31:0]         rdata,
    // AXI read address
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    // AXI read data
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata_axi,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // AXI write address
    output logic [ID_WIDTH-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    // AXI write data
    output logic [ID_WIDTH-1:0] wid,
    output logic [31:0]         wdata_axi,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    // AXI write response
    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e      state_q, state_d;

    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        accept;

    // Response ids/status and rlast carry nothing this block acts on.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

    assign accept = (state_q == IDLE) && req;

    // Byte lanes for the incoming request; size 3 behaves as a word.
    always_comb begin
        wstrb_d = 4'b1111;
        case (size)
            2'd0:    wstrb_d = 4'b0001 << addr[1:0];
            2'd1:    wstrb_d = 4'b0011 << addr[1:0];
            default: wstrb_d = 4'b1111;
        endcase
    end

    // Handshake flags persist while in WR_REQ so AW and W can finish in
    // either order; they clear whenever the FSM is elsewhere.
    always_comb begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (state_q == WR_REQ) begin
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q  | wready;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read data and write handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (accept) begin
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
                wstrb_q <= wstrb_d;
            end
            if ((state_q == RD_DATA) && rvalid) begin
                rdata_q <= rdata_axi;
            end
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Output logic
    always_comb begin
        addr_ok   = accept;
        data_ok   = (state_q == DONE);
        rdata     = rdata_q;

        arid      = AXI_ID;
        araddr    = addr_q;
        arlen     = 8'd0;
        arsize    = {1'b0, size_q};
        arburst   = 2'b01;
        arvalid   = (state_q == RD_ADDR);
        rready    = (state_q == RD_DATA);

        awid      = AXI_ID;
        awaddr    = addr_q;
        awlen     = 8'd0;
        awsize    = {1'b0, size_q};
        awburst   = 2'b01;
        awvalid   = (state_q == WR_REQ) && !aw_done_q;

        wid       = AXI_ID;
        wdata_axi = wdata_q;
        wstrb     = wstrb_q;
        wlast     = 1'b1;
        wvalid    = (state_q == WR_REQ) && !w_done_q;

        bready    = (state_q == WR_RESP);
    end

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// tb_sram_like_axi_bridge: drives directed and random sram-like requests
// against a cycle-count reference of the bridge and a scripted AXI slave.

module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic [3:0]  wstrb;
    logic        bvalid, bready;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    sram_like_axi_bridge #(.ID_WIDTH(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Byte-enable mask: n bytes starting at the addressed lane.
    function automatic logic [3:0] strb_of(input logic [1:0] sz,
                                           input logic [31:0] a);
        int n;
        int off;
        n   = (sz >= 2) ? 4 : (1 << sz);
        off = (n == 4) ? 0 : int'(a[1:0]);
        return 4'(((1 << n) - 1) << off);
    endfunction

    task automatic slave_idle();
        arready   = 1'b0;
        rvalid    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        rdata_axi = $urandom;
        rid       = 4'($urandom);
        bid       = 4'($urandom);
        rresp     = 2'($urandom);
        bresp     = 2'($urandom);
        rlast     = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            slave_idle();
            #1;
            chk("idle_addr_ok", addr_ok, 0);
            chk("idle_data_ok", data_ok, 0);
            chk("idle_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
            chk("idle_rdata", rdata, m_rdata);
        end
    endtask

    // One request. Cycle 0 is the accept cycle; the slave answers each
    // channel after the given number of extra wait cycles.
    task automatic txn(input bit tw, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd,
                       input int ard, input int rvd,
                       input int awd, input int wd, input int bd,
                       input bit keep, input int rst_at);
        int m;
        int done;
        bit e_arv, e_rr, e_awv, e_wv, e_br;
        m    = (awd > wd) ? awd : wd;
        done = tw ? (3 + m + bd) : (3 + ard + rvd);
        for (int c = 0; c <= done; c++) begin
            @(negedge clk);
            slave_idle();
            req = (c == 0) || keep;
            if (c == 0) begin
                wr    = tw;
                size  = sz;
                addr  = a;
                wdata = d;
            end
            arready = !tw && (c == 1 + ard);
            rvalid  = !tw && (c == 2 + ard + rvd);
            if (rvalid) rdata_axi = rd;
            awready = tw && (c == 1 + awd);
            wready  = tw && (c == 1 + wd);
            bvalid  = tw && (c == 2 + m + bd);
            rst     = (c == rst_at);
            #1;
            e_arv = !tw && c >= 1 && c <= 1 + ard;
            e_rr  = !tw && c >= 2 + ard && c <= 2 + ard + rvd;
            e_awv = tw && c >= 1 && c <= 1 + awd;
            e_wv  = tw && c >= 1 && c <= 1 + wd;
            e_br  = tw && c >= 2 + m && c <= 2 + m + bd;
            if (!tw && c == done) m_rdata = rd;
            chk("addr_ok", addr_ok, (c == 0));
            chk("data_ok", data_ok, (c == done));
            chk("arvalid", arvalid, e_arv);
            chk("rready", rready, e_rr);
            chk("awvalid", awvalid, e_awv);
            chk("wvalid", wvalid, e_wv);
            chk("bready", bready, e_br);
            chk("rdata", rdata, m_rdata);
            if (e_arv) begin
                chk("araddr", araddr, a);
                chk("arsize", arsize, {1'b0, sz});
            end
            if (e_awv) begin
                chk("awaddr", awaddr, a);
                chk("awsize", awsize, {1'b0, sz});
            end
            if (e_wv) begin
                chk("wdata_axi", wdata_axi, d);
                chk("wstrb", wstrb, strb_of(sz, a));
                chk("wlast", wlast, 1);
            end
            if (c == rst_at) break;
        end
        if (rst_at >= 0) begin
            @(negedge clk);
            rst = 1'b0;
            req = 1'b0;
            slave_idle();
            m_rdata = 32'd0;
            #1;
            chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
            chk("rst_data_ok", data_ok, 0);
            chk("rst_addr_ok", addr_ok, 0);
            chk("rst_rdata", rdata, 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        wr    = 1'b0;
        size  = 2'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        m_rdata = 32'd0;
        slave_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_data_ok", data_ok, 0);
        chk("reset_addr_ok", addr_ok, 0);
        chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_wstrb", wstrb, 0);
        chk("reset_bursts", {arburst, awburst}, 4'b0101);
        chk("reset_wlast", wlast, 1);
        chk("reset_ids", {arid, awid, wid}, 12'h111);
        chk("reset_lens", {arlen, awlen}, 0);
        rst = 1'b0;

        // Word read, zero-wait slave
        txn(0, 2'd2, 32'h1FC0_0010, 32'h0, 32'hDEADBEEF,
            0, 0, 0, 0, 0, 0, -1);
        // Byte write to top lane
        txn(1, 2'd0, 32'h8000_0003, 32'hAA00_0000, 32'h0,
            0, 0, 0, 0, 0, 0, -1);
        // AW accepted at once, W held off three cycles
        txn(1, 2'd2, 32'h0000_1000, 32'h1234_5678, 32'h0,
            0, 0, 0, 3, 1, 0, -1);
        // AR backpressure while the core keeps req high
        txn(0, 2'd2, 32'h0000_2004, 32'h0, 32'hCAFE_F00D,
            5, 1, 0, 0, 0, 1, -1);
        // Reset while waiting for read data
        txn(0, 2'd2, 32'h0000_3008, 32'h0, 32'h5555_AAAA,
            0, 3, 0, 0, 0, 0, 3);
        // Read then halfword write to upper half
        txn(0, 2'd1, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE,
            0, 0, 0, 0, 0, 0, -1);
        txn(1, 2'd1, 32'h8000_0002, 32'hBEEF_0000, 32'h0,
            0, 0, 0, 0, 0, 0, -1);
        idle(2);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom);
            a  = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            txn(1'($urandom), sz, a, $urandom, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), 1'($urandom),
                ($urandom_range(0, 15) == 0) ? 2 : -1);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
